// File: rtl/instr_encoder_if.sv
// Request/response bundle between a field-level instruction source and
// the instruction encoder / memory-loader side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] word_count;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd,
    output in_funct, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr,
    input  err, word_count
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd,
    input  in_funct, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_addr,
    output err, word_count
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: field requests in, encoded words out through
// a small FIFO with a running word-aligned load address.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] K_R   = 2'b00;
  localparam logic [1:0] K_LW  = 2'b01;
  localparam logic [1:0] K_SW  = 2'b10;
  localparam logic [1:0] K_BEQ = 2'b11;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   wc_q, wc_d;
  logic          err_q, err_d;

  logic [31:0] word;
  logic        legal;
  logic        funct_ok;
  logic        acc;
  logic        push;
  logic        pop;
  logic        in_ready;
  logic        out_valid;

  assign in_ready  = (cnt_q != FULL);
  assign out_valid = (cnt_q != '0);

  always_comb begin
    funct_ok = bus.in_funct inside
      {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    word  = '0;
    legal = 1'b1;
    unique case (bus.in_kind)
      K_R: begin
        word  = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd,
                 5'b00000, bus.in_funct};
        legal = funct_ok;
      end
      K_LW:  word = {OP_LW, bus.in_rs, bus.in_rt, bus.in_imm};
      K_SW:  word = {OP_SW, bus.in_rs, bus.in_rt, bus.in_imm};
      K_BEQ: word = {OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm};
    endcase
  end

  always_comb begin
    acc  = bus.in_valid && in_ready;
    push = acc && legal;
    pop  = out_valid && bus.out_ready;

    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (!push && pop)
      cnt_d = cnt_q - CW'(1);

    addr_d = pop ? addr_q + 32'd4 : addr_q;
    wc_d   = wc_q;
    if (pop && wc_q != 16'hFFFF)
      wc_d = wc_q + 16'd1;
    err_d  = err_q | (acc && !legal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      addr_q <= BASE_ADDR;
      wc_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      wc_q   <= wc_d;
      err_q  <= err_d;
    end
  end

  // storage is not cleared; out_word is masked while empty instead
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_q[wr_q] <= word;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_word   = out_valid ? mem_q[rd_q] : 32'h0;
  assign bus.out_addr   = addr_q;
  assign bus.err        = err_q;
  assign bus.word_count = wc_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed checks of instr_encoder against a queue-based
// reference model.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if b();
  instr_encoder_if w();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(rst), .bus(b)
  );
  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WBASE)) u_wrap (
    .clk(clk), .reset(rst), .bus(w)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] q[$];
  logic [31:0] m_addr;
  bit          m_err;
  int          m_cnt;
  logic [5:0]  legal_f [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit legal_req(logic [1:0] k, logic [5:0] f);
    if (k != 2'd0) return 1'b1;
    foreach (legal_f[i]) if (legal_f[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] enc(logic [1:0] k, logic [4:0] rs,
    logic [4:0] rt, logic [4:0] rd, logic [5:0] f, logic [15:0] imm);
    longint v;
    longint op;
    case (k)
      2'd0: op = 0;
      2'd1: op = 35;
      2'd2: op = 43;
      default: op = 4;
    endcase
    v = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536;
    if (k == 2'd0) v = v + longint'(rd) * 2048 + longint'(f);
    else v = v + longint'(imm);
    return v[31:0];
  endfunction

  task automatic drive(bit v, logic [1:0] k, logic [4:0] rs, logic [4:0] rt,
    logic [4:0] rd, logic [5:0] f, logic [15:0] imm, bit ordy);
    b.in_valid  = v;
    b.in_kind   = k;
    b.in_rs     = rs;
    b.in_rt     = rt;
    b.in_rd     = rd;
    b.in_funct  = f;
    b.in_imm    = imm;
    b.out_ready = ordy;
  endtask

  task automatic rand_req(bit v, bit ordy, bit bad_ok);
    logic [5:0] f;
    f = legal_f[$urandom_range(0, 4)];
    if (bad_ok && $urandom_range(0, 3) == 0) f = 6'($urandom());
    drive(v, 2'($urandom()), 5'($urandom()), 5'($urandom()),
          5'($urandom()), f, 16'($urandom()), ordy);
  endtask

  task automatic compare();
    check("in_ready", 32'(b.in_ready), 32'(q.size() != DEPTH));
    check("out_valid", 32'(b.out_valid), 32'(q.size() != 0));
    check("out_word", b.out_word, (q.size() != 0) ? q[0] : 32'h0);
    check("out_addr", b.out_addr, m_addr);
    check("err", 32'(b.err), 32'(m_err));
    check("word_count", 32'(b.word_count), 32'(m_cnt));
  endtask

  task automatic tick();
    bit acc;
    bit pop;
    bit lg;
    logic [31:0] wd;
    acc = b.in_valid && (q.size() != DEPTH);
    pop = (q.size() != 0) && b.out_ready;
    lg  = legal_req(b.in_kind, b.in_funct);
    wd  = enc(b.in_kind, b.in_rs, b.in_rt, b.in_rd, b.in_funct, b.in_imm);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_addr = m_addr + 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end
      if (acc) begin
        if (lg) q.push_back(wd);
        else m_err = 1'b1;
      end
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [31:0] wl [4];
    logic [31:0] wa [3];
    wl = '{32'h00221820, 32'h8C080004, 32'hAC080004, 32'h1022FFFF};
    wa = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    m_addr = BASE;
    m_err  = 1'b0;
    m_cnt  = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    w.in_valid = 0; w.in_kind = 2'd1; w.in_rs = 0; w.in_rt = 0;
    w.in_rd = 0; w.in_funct = 0; w.in_imm = 16'd4; w.out_ready = 0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    drive(1, 2'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 0); tick();
    drive(1, 2'd1, 5'd0, 5'd8, 5'd0, 6'h00, 16'd4, 0); tick();
    drive(1, 2'd2, 5'd0, 5'd8, 5'd0, 6'h00, 16'd4, 0); tick();
    drive(1, 2'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 0); tick();
    check("full_ready", 32'(b.in_ready), 32'd0);
    drive(1, 2'd1, 5'd7, 5'd7, 5'd0, 6'h00, 16'd9, 0); tick();
    check("stall_word", b.out_word, wl[0]);
    for (int i = 0; i < 4; i++) begin
      check("kind_word", b.out_word, wl[i]);
      check("kind_addr", b.out_addr, BASE + 32'(4 * i));
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    check("drain_ready", 32'(b.in_ready), 32'd1);
    check("drain_valid", 32'(b.out_valid), 32'd0);

    drive(1, 2'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 1); tick();
    drive(1, 2'd0, 5'd4, 5'd5, 5'd6, 6'h00, 16'd0, 1); tick();
    check("err_rise", 32'(b.err), 32'd1);
    drive(1, 2'd1, 5'd3, 5'd4, 5'd0, 6'h00, 16'h10, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    check("illegal_addr", b.out_addr, BASE + 32'd24);
    check("illegal_count", 32'(b.word_count), 32'd6);
    check("err_hold", 32'(b.err), 32'd1);

    for (int i = 0; i < 3; i++) begin
      rand_req(1, 0, 0);
      tick();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(b.out_valid), 32'd0);
    check("rst_addr", b.out_addr, BASE);
    check("rst_count", 32'(b.word_count), 32'd0);
    check("rst_err", 32'(b.err), 32'd0);

    for (int i = 0; i < 20; i++) begin
      rand_req(1, 1, 0);
      tick();
    end
    check("stream_count", 32'(b.word_count), 32'd19);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      rand_req($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 1);
      tick();
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      rand_req(1, 1, 0);
      tick();
    end
    check("sat_count", 32'(b.word_count), 32'h0000FFFF);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    w.in_valid  = 1'b1;
    w.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    w.in_valid  = 1'b0;
    w.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("wrap_addr", w.out_addr, wa[i]);
      check("wrap_valid", 32'(w.out_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    check("wrap_empty", 32'(w.out_valid), 32'd0);
    check("wrap_count", 32'(w.word_count), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder that builds MIPS instruction words for the single-cycle datapath's opcode/funct decode (R-format, lw, sw, beq). It takes field-level instruction requests over a valid/ready handshake and encodes them into 32-bit words. It buffers the words in a small FIFO and presents them, each with a word-aligned address, to the instruction-memory loader. Illegal requests are dropped and flagged.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- BASE_ADDR, 32'h0000_0000: address of first emitted word (word aligned)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- in_kind  in  2  00 R-format, 01 lw, 10 sw, 11 beq
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field (R-format only)
- in_funct  in  6  funct (R-format only)
- in_imm  in  16  immediate/offset (lw, sw, beq)
- out_valid  out  1  out_word/out_addr valid
- out_ready  in  1  loader accepts word
- out_word  out  32  encoded instruction
- out_addr  out  32  byte address of out_word
- err  out  1  sticky: an illegal request was dropped
- word_count  out  16  words emitted, saturating

## Operation
- Encoding (bits 31:26 opcode):
  - R: {000000, rs, rt, rd, 00000, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - Unused inputs for a kind are ignored.
- Legal R funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal.
- Accept: in_valid && in_ready.
  - A legal request writes its encoded word to the FIFO tail.
  - An illegal request is consumed but not written. err is set and held until reset.
- FIFO: DEPTH entries with read/write pointers that wrap modulo DEPTH, and an occupancy counter 0..DEPTH.
  - in_ready = (occupancy != DEPTH).
  - out_valid = (occupancy != 0).
  - out_word = head entry.
- Pop: out_valid && out_ready.
  - The head advances.
  - out_addr += 4. It wraps modulo 2^32 without error.
  - word_count += 1, saturating at 16'hFFFF.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
- When full, in_ready = 0 even if a pop occurs that same cycle. A push is never accepted on a full-cycle.
- An illegal accept in the same cycle as a pop: occupancy decrements.
- out_word and out_addr must stay stable while out_valid && !out_ready.

## Timing
- Reset (synchronous, on clk while reset=1):
  - Pointers and occupancy 0, so out_valid=0 and in_ready=1.
  - out_addr = BASE_ADDR, err = 0, word_count = 0.
  - out_word = 0 (FIFO contents need not be cleared).
- Reset mid-operation discards all buffered words. A handshake in the reset cycle has no effect.
- Latency: a word accepted in cycle N has out_valid=1 in cycle N+1 if the FIFO was empty. There is no combinational in→out bypass.
- in_ready depends only on registered occupancy, never on out_ready.
- err rises the cycle after the illegal accept.
- Throughput is one word per cycle sustained when out_ready is held high.

## Test plan
- Reset then encode each kind:
  - R add (rs=1, rt=2, rd=3, funct=100000) gives 32'h00221820.
  - lw rs=0, rt=8, imm=4 gives 32'h8C080004.
  - sw rs=0, rt=8, imm=4 gives 32'hAC080004.
  - beq rs=1, rt=2, imm=16'hFFFF gives 32'h1022FFFF.
  - Addresses are BASE_ADDR, +4, +8, +12.
- Backpressure: hold out_ready=0 and push 5 legal requests.
  - in_ready=0 after 4 accepts.
  - out_word is stable at the first word.
  - Release out_ready: 4 words emit in order with consecutive addresses, then in_ready=1.
- Illegal funct 000000 between two legal requests:
  - err=1 the next cycle.
  - Only 2 words are emitted.
  - out_addr increments by 4 only twice.
  - err persists until reset.
- Streaming with in_valid=1 and out_ready=1 for 20 cycles: one word per cycle, occupancy ≤1, word_count=19 or 20 as counted.
- Reset asserted with 3 words buffered: next cycle out_valid=0, out_addr=BASE_ADDR, word_count=0, err=0.
- Address wrap: BASE_ADDR=32'hFFFF_FFF8 with 3 pops gives addresses FFFFFFF8, FFFFFFFC, 00000000.
